// File: rtl/scan_pkg.sv
// Shared types for the scan-chain sequencer and its companion chain model.
package scan_pkg;

    // Sequencer states. IDLE waits for a host request, CAPTURE pulses the
    // chain's parallel load, SHIFT moves CHAIN_LEN bits, DONE returns data.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } scan_state_t;

endpackage : scan_pkg

// File: rtl/scan_chain.sv
// Parallel-loadable scan-chain shift register driven by scan_chain_ctrl.
// Serial data enters at the MSB and bit 0 is the serial output; a parallel
// load takes priority over a shift.
module scan_chain #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ld,
    input  logic         en,
    input  logic         d,
    input  logic [N-1:0] pd,
    output logic         q,
    output logic [N-1:0] dout
);

    logic [N-1:0] r_q;
    logic [N-1:0] r_d;

    // Next chain contents: load beats shift, otherwise hold.
    always_comb begin
        r_d = r_q;
        if (ld) begin
            r_d = pd;
        end else if (en) begin
            r_d = N'({d, r_q} >> 1);
        end else begin
            r_d = r_q;
        end
    end

    // Chain flops, cleared only by the chain's own reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign q    = r_q[0];
    assign dout = r_q;

endmodule : scan_chain

// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: on a host start it optionally captures datapath
// state into the chain, shifts exactly CHAIN_LEN bits (new word in, old
// contents out) and returns the collected word with a one-cycle done.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 capture,
    input  logic [CHAIN_LEN-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 scan_ld,
    output logic                 scan_en,
    output logic                 scan_d,
    input  logic                 scan_q
);

    // Counter value seen during the final shift cycle. Comparing against
    // CHAIN_LEN-1 keeps CHAIN_LEN=1 down to a single shift cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          state_q, state_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rx_q, rx_d;
    logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Next-state and datapath update; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // capture is consumed here; the chosen path carries it
                    tx_d    = wdata;
                    cnt_d   = '0;
                    state_d = capture ? S_CAPTURE : S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // LSB of tx leaves on scan_d; chain bit 0 enters rx at MSB
                tx_d  = tx_q >> 1;
                rx_d  = CHAIN_LEN'({scan_q, rx_q} >> 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                rdata_d = rx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from registered state only, so reset drops the chain
    // strobes immediately and ld/en can never overlap.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        scan_ld = 1'b0;
        scan_en = 1'b0;
        scan_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CAPTURE: begin
                busy    = 1'b1;
                scan_ld = 1'b1;
            end
            S_SHIFT: begin
                busy    = 1'b1;
                scan_en = 1'b1;
                scan_d  = tx_q[0];
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rdata = rdata_q;

endmodule : scan_chain_ctrl

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl driving real scan chains
// (CHAIN_LEN=8 and CHAIN_LEN=1), checked against a word-level model.
module tb_scan_chain_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // CHAIN_LEN=8 instance
    logic       start8, cap8, busy8, done8, ld8, en8, d8, q8;
    logic [7:0] wdata8, rdata8, pd8, chain8;
    // CHAIN_LEN=1 instance
    logic       start1, cap1, busy1, done1, ld1, en1, d1, q1;
    logic [0:0] wdata1, rdata1, pd1, chain1;

    scan_chain_ctrl #(.CHAIN_LEN(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .capture(cap8), .wdata(wdata8),
        .busy(busy8), .done(done8), .rdata(rdata8),
        .scan_ld(ld8), .scan_en(en8), .scan_d(d8), .scan_q(q8)
    );
    scan_chain #(.N(8)) u_chain8 (
        .clk(clk), .rstn(~rst), .ld(ld8), .en(en8), .d(d8), .pd(pd8),
        .q(q8), .dout(chain8)
    );

    scan_chain_ctrl #(.CHAIN_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .capture(cap1), .wdata(wdata1),
        .busy(busy1), .done(done1), .rdata(rdata1),
        .scan_ld(ld1), .scan_en(en1), .scan_d(d1), .scan_q(q1)
    );
    scan_chain #(.N(1)) u_chain1 (
        .clk(clk), .rstn(~rst), .ld(ld1), .en(en1), .d(d1), .pd(pd1),
        .q(q1), .dout(chain1)
    );

    int n_err = 0;
    int n_chk = 0;
    int ld_en_viol = 0;

    // Word-level model of what each chain holds.
    logic [7:0] model8;
    logic [0:0] model1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Load and shift strobes must never be high together on either chain.
    always @(negedge clk) begin
        if ((ld8 & en8) | (ld1 & en1)) ld_en_viol++;
    end

    // One operation on the 8-bit chain. inj_a: cycle index where a stray
    // start is pulsed (0 = none); inj_done: also pulse start during DONE.
    task automatic run_op8(input logic [7:0] wd, input logic cap, input logic [7:0] pd,
                           input int inj_a, input bit inj_done);
        int         cyc, n_en, n_ld, first_ld, exp_lat;
        logic [7:0] sd, exp_r;
        bit         got;
        if (cap) model8 = pd;
        exp_r   = model8;
        model8  = wd;
        exp_lat = cap ? 10 : 9;

        pd8 = pd; wdata8 = wd; cap8 = cap; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wdata8 = 8'($urandom);
        cap8   = 1'($urandom);
        chk("busy_after_start", 32'(busy8), 32'd1);

        cyc = 1; n_en = 0; n_ld = 0; first_ld = 0; sd = 8'h00; got = 1'b0;
        while (cyc <= 16 && !got) begin
            if (ld8) begin
                n_ld++;
                if (first_ld == 0) first_ld = cyc;
            end
            if (en8) begin
                if (n_en < 8) sd[n_en] = d8;
                n_en++;
            end
            if (done8) begin
                got = 1'b1;
            end else begin
                start8 = (cyc == inj_a);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start8 = got && inj_done;
        @(posedge clk); #1;
        start8 = 1'b0;

        chk("done_seen",    32'(got),      32'd1);
        chk("latency",      32'(cyc),      32'(exp_lat));
        chk("en_cycles",    32'(n_en),     32'd8);
        chk("ld_cycles",    32'(n_ld),     cap ? 32'd1 : 32'd0);
        chk("ld_cycle_idx", 32'(first_ld), cap ? 32'd1 : 32'd0);
        chk("scan_d_seq",   32'(sd),       32'(wd));
        chk("rdata",        32'(rdata8),   32'(exp_r));
        chk("chain_out",    32'(chain8),   32'(wd));
        chk("idle_busy",    32'(busy8),    32'd0);
        chk("idle_done",    32'(done8),    32'd0);
    endtask

    // One operation on the 1-bit chain.
    task automatic run_op1(input logic [0:0] wd, input logic cap, input logic [0:0] pd);
        int         cyc, exp_lat;
        logic [0:0] exp_r;
        if (cap) model1 = pd;
        exp_r   = model1;
        model1  = wd;
        exp_lat = cap ? 3 : 2;

        pd1 = pd; wdata1 = wd; cap1 = cap; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wdata1 = 1'($urandom);
        cap1   = 1'($urandom);
        cyc = 1;
        while (cyc <= 8 && !done1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("l1_done_seen", 32'(done1), 32'd1);
        chk("l1_latency",   32'(cyc),   32'(exp_lat));
        @(posedge clk); #1;
        chk("l1_rdata",     32'(rdata1), 32'(exp_r));
        chk("l1_chain_out", 32'(chain1), 32'(wd));
        chk("l1_idle_busy", 32'(busy1),  32'd0);
    endtask

    initial begin
        start8 = 1'b0; cap8 = 1'b0; wdata8 = 8'h00; pd8 = 8'h00;
        start1 = 1'b0; cap1 = 1'b0; wdata1 = 1'b0;  pd1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy8),  32'd0);
        chk("rst_done",   32'(done8),  32'd0);
        chk("rst_ld",     32'(ld8),    32'd0);
        chk("rst_en",     32'(en8),    32'd0);
        chk("rst_d",      32'(d8),     32'd0);
        chk("rst_rdata",  32'(rdata8), 32'd0);
        chk("rst_busy1",  32'(busy1),  32'd0);
        rst = 1'b0;
        model8 = 8'h00;
        model1 = 1'b0;
        @(posedge clk); #1;

        // Directed: plain shift, capture, back-to-back, ignored starts.
        run_op8(8'hA5, 1'b0, 8'h00, 0, 1'b0);
        run_op8(8'h00, 1'b1, 8'h3C, 0, 1'b0);
        run_op8(8'h5A, 1'b0, 8'h11, 0, 1'b0);
        run_op8(8'hFF, 1'b0, 8'h22, 0, 1'b0);
        run_op8(8'h96, 1'b0, 8'h00, 3, 1'b1);
        run_op8(8'h3C, 1'b1, 8'hC3, 4, 1'b1);

        // Reset in SHIFT cycle 3: strobes, busy and rdata drop at once.
        wdata8 = 8'h77; cap8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_en", 32'(en8), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_en",    32'(en8),    32'd0);
        chk("mid_rst_ld",    32'(ld8),    32'd0);
        chk("mid_rst_busy",  32'(busy8),  32'd0);
        chk("mid_rst_rdata", 32'(rdata8), 32'd0);
        chk("mid_rst_done",  32'(done8),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model8 = 8'h00;
        model1 = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(done8), 32'd0);
        run_op8(8'hE1, 1'b0, 8'h00, 0, 1'b0);

        // Randomized operations against the word-level model.
        for (int i = 0; i < 24; i++) begin
            run_op8(8'($urandom), 1'($urandom), 8'($urandom),
                    int'($urandom_range(9, 0)), 1'($urandom));
        end

        // Single-flop chain.
        run_op1(1'b1, 1'b1, 1'b0);
        run_op1(1'b0, 1'b0, 1'b1);
        run_op1(1'b1, 1'b1, 1'b1);

        chk("ld_en_overlap", 32'(ld_en_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard stop if something wedges the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule : tb_scan_chain_ctrl

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer for a parallel-loadable scan-chain shift register (LSB shifts out, serial data enters at MSB, `ld` has priority over `en`). On a host `start` it optionally pulses the chain's parallel load to capture datapath state. It then shifts exactly CHAIN_LEN bits, feeding a new host word in and collecting the old contents out, and returns the collected word with a one-cycle `done`. It sits between the host/config interface and each DPE scan chain, so the chain's enable, load and serial input are never driven by hand.

## Interface
- CHAIN_LEN, 8, number of flops in the controlled chain (≥1)
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request one scan operation; honoured only in IDLE
- capture  in  1  sampled with start; 1 = pulse scan_ld before shifting
- wdata  in  CHAIN_LEN  word to shift into the chain, registered at accepted start
- busy  out  1  high in CAPTURE, SHIFT, DONE
- done  out  1  one-cycle pulse in DONE
- rdata  out  CHAIN_LEN  word shifted out of the chain; updated in DONE, held otherwise
- scan_ld  out  1  to chain `ld`
- scan_en  out  1  to chain `en`
- scan_d  out  1  to chain serial input `d`
- scan_q  in  1  chain bit 0 (serial output)

## Operation
- States: IDLE, CAPTURE, SHIFT, DONE.
- IDLE: if start=1, latch wdata into tx_reg and capture into cap_flag, clear the counter, and go to CAPTURE (cap_flag=1) or SHIFT (cap_flag=0).
- CAPTURE: scan_ld=1 for one cycle, scan_en=0; next state SHIFT.
- SHIFT: scan_en=1 and scan_d=tx_reg[0]. Each cycle tx_reg shifts right, rx_reg <= {scan_q, rx_reg[CHAIN_LEN-1:1]} and the counter increments. After CHAIN_LEN cycles, go to DONE.
- DONE: rdata <= rx_reg, done=1; next state IDLE.
- Bit order: chain bit i exits in SHIFT cycle i and lands in rdata[i]. wdata[i] is sent in cycle i and ends in chain bit i. After DONE, chain out == wdata.
- scan_ld and scan_en are never high together. All scan_* outputs are decoded from registered state and registers only, with no combinational path from inputs.
- start in CAPTURE, SHIFT or DONE is ignored and not queued. wdata and capture changes after acceptance have no effect.

## Timing
- Reset (async assert, sync release): state=IDLE; busy, done, scan_ld, scan_en, scan_d = 0; rdata, tx_reg, rx_reg, counter = 0.
- start sampled high at edge 0 → busy=1 from cycle 1. If capture=1, CAPTURE is cycle 1 and SHIFT is cycles 2..CHAIN_LEN+1. If capture=0, SHIFT is cycles 1..CHAIN_LEN.
- DONE follows the last SHIFT cycle. Latency from start to done = CHAIN_LEN+1 (no capture) or CHAIN_LEN+2 (capture). rdata is valid the cycle after the done pulse.
- Back-to-back: earliest re-accept is the IDLE cycle after DONE. Minimum issue interval = CHAIN_LEN+2 (no capture) or CHAIN_LEN+3 (capture).
- rst mid-operation: scan_en and scan_ld drop immediately (asynchronously), state returns to IDLE, and rdata clears. The chain is left partially shifted; it is cleared only by the chain's own reset.
- CHAIN_LEN=1: exactly one SHIFT cycle, and the counter wraps check is `cnt == CHAIN_LEN-1`.

## Structure
- Shared package `scan_pkg`: `scan_state_t` enum {S_IDLE, S_CAPTURE, S_SHIFT, S_DONE}.
- No sub-module. The counter, tx_reg and rx_reg are local.
- The bench instantiates the real shift-register chain with `rstn = ~rst`.

## Test plan
- CHAIN_LEN=8, chain freshly reset, start with capture=0 and wdata=0xA5 → done at cycle 9, rdata=0x00, chain out=0xA5. The scan_d sequence is 1,0,1,0,0,1,0,1.
- Chain pd=0x3C, start with capture=1 and wdata=0x00 → scan_ld high only in cycle 1, done at cycle 10, rdata=0x3C, chain out=0x00.
- Two back-to-back ops, wdata 0x5A then 0xFF with no capture → second rdata=0x5A, chain out=0xFF. Second start accepted exactly in the IDLE cycle after the first done.
- start pulsed during SHIFT and during DONE → ignored: one done only, and no change to rdata or chain.
- rst asserted in SHIFT cycle k=3 → scan_en=0, busy=0 and rdata=0 the same cycle, no done. A following normal op completes correctly.
- CHAIN_LEN=1, wdata=1, capture=1 with pd=0 → rdata=0, chain out=1, done at cycle 3.
